// File: rtl/mgmt_gpio_pkg.sv
// Shared sizing defaults for the management GPIO input path.
// Optional debounce counters are controlled by the MGMT_GPIO_DEBOUNCE_EN macro.
package mgmt_gpio_pkg;

  localparam int MGMT_GPIO_WIDTH       = 18;
  localparam int MGMT_GPIO_SYNC_STAGES = 2;
  localparam int MGMT_GPIO_DEBOUNCE_W  = 4;

endpackage

// File: rtl/mgmt_gpio_in_bit.sv
// One GPIO input bit: synchronizer, optional debounce, stable register, sticky edge status.
// Debounce counter is present only when MGMT_GPIO_DEBOUNCE_EN is defined.
module mgmt_gpio_in_bit
  import mgmt_gpio_pkg::*;
#(
  parameter int SYNC_STAGES = MGMT_GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_W  = MGMT_GPIO_DEBOUNCE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  rise_en,
  input  logic                  fall_en,
  input  logic                  irq_clr,
  input  logic [DEBOUNCE_W-1:0] dbnc_limit,
  output logic                  val,
  output logic                  status
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   s;
  logic                   update;
  logic                   val_reg;
  logic                   status_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
    end
  end

  assign s = sync_reg[SYNC_STAGES-1];

`ifdef MGMT_GPIO_DEBOUNCE_EN
  logic [DEBOUNCE_W-1:0] cnt_reg;

  // >= rather than == so a limit lowered below a running count updates at once.
  assign update = (s != val_reg) && (cnt_reg >= dbnc_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if ((s == val_reg) || update) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + {{(DEBOUNCE_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic dbnc_unused;

  assign dbnc_unused = ^dbnc_limit;
  assign update      = (s != val_reg);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_reg    <= 1'b0;
      status_reg <= 1'b0;
    end else begin
      if (update) begin
        val_reg <= s;
      end
      // Set terms are ORed after the clear so a same-cycle event wins.
      status_reg <= (status_reg & ~irq_clr)
                  | (update &  s & rise_en)
                  | (update & ~s & fall_en);
    end
  end

  assign val    = val_reg;
  assign status = status_reg;

endmodule

// File: rtl/mgmt_gpio_in_sync.sv
// Management GPIO input receive path: WIDTH independent bit slices plus the OR'd interrupt.
// Debounce behaviour depends on the MGMT_GPIO_DEBOUNCE_EN macro (see mgmt_gpio_in_bit).
module mgmt_gpio_in_sync
  import mgmt_gpio_pkg::*;
#(
  parameter int WIDTH       = MGMT_GPIO_WIDTH,
  parameter int SYNC_STAGES = MGMT_GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_W  = MGMT_GPIO_DEBOUNCE_W
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [WIDTH-1:0]      gpio_in,
  input  logic [WIDTH-1:0]      rise_en,
  input  logic [WIDTH-1:0]      fall_en,
  input  logic [WIDTH-1:0]      irq_clr,
  input  logic [DEBOUNCE_W-1:0] dbnc_limit,
  output logic [WIDTH-1:0]      gpio_val,
  output logic [WIDTH-1:0]      irq_status,
  output logic                  irq
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      mgmt_gpio_in_bit #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE_W  (DEBOUNCE_W)
      ) u_bit (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .din        (gpio_in[gi]),
        .rise_en    (rise_en[gi]),
        .fall_en    (fall_en[gi]),
        .irq_clr    (irq_clr[gi]),
        .dbnc_limit (dbnc_limit),
        .val        (gpio_val[gi]),
        .status     (irq_status[gi])
      );
    end
  endgenerate

  assign irq = |irq_status;

endmodule

// File: tb/tb_mgmt_gpio_in_sync.sv
// Self-checking bench for mgmt_gpio_in_sync: table vectors, directed corner sequences, random run.
// Expected debounce timing follows MGMT_GPIO_DEBOUNCE_EN (limit treated as 0 when undefined).
module tb_mgmt_gpio_in_sync;

  localparam int W    = 18;
  localparam int SYNC = 2;
  localparam int DW   = 4;
`ifdef MGMT_GPIO_DEBOUNCE_EN
  localparam bit DBNC_ON = 1'b1;
`else
  localparam bit DBNC_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  gpio_in = '0;
  logic [W-1:0]  rise_en = '0;
  logic [W-1:0]  fall_en = '0;
  logic [W-1:0]  irq_clr = '0;
  logic [DW-1:0] dbnc_limit = '0;
  logic [W-1:0]  gpio_val;
  logic [W-1:0]  irq_status;
  logic          irq;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  mgmt_gpio_in_sync #(.WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_W(DW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .gpio_in    (gpio_in),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_clr    (irq_clr),
    .dbnc_limit (dbnc_limit),
    .gpio_val   (gpio_val),
    .irq_status (irq_status),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: delay line of raw inputs, per-bit run length of mismatching cycles.
  logic [W-1:0] m_line [SYNC];
  logic [W-1:0] m_val;
  logic [W-1:0] m_status;
  int           m_run [W];

  function automatic int eff_limit(input int l);
    return DBNC_ON ? l : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_line[j] = '0;
    m_val    = '0;
    m_status = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] in, input logic [W-1:0] ren,
                            input logic [W-1:0] fen, input logic [W-1:0] clr, input int lim);
    logic [W-1:0] s;
    logic [W-1:0] upd;
    s   = m_line[SYNC-1];
    upd = '0;
    for (int i = 0; i < W; i++) begin
      if (s[i] == m_val[i]) begin
        m_run[i] = 0;
      end else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] > lim) begin
          upd[i]   = 1'b1;
          m_run[i] = 0;
        end
      end
    end
    m_status = (m_status & ~clr) | (upd & s & ren) | (upd & ~s & fen);
    m_val    = (m_val & ~upd) | (s & upd);
    for (int j = SYNC - 1; j > 0; j--) m_line[j] = m_line[j-1];
    m_line[0] = in;
  endtask

  // One clock: capture pre-edge inputs, advance the model, compare #1 after the edge.
  task automatic tick();
    logic [W-1:0] in_c, ren_c, fen_c, clr_c;
    int           lim_c;
    in_c  = gpio_in;
    ren_c = rise_en;
    fen_c = fall_en;
    clr_c = irq_clr;
    lim_c = eff_limit(int'(dbnc_limit));
    @(posedge clk);
    cyc++;
    model_edge(in_c, ren_c, fen_c, clr_c, lim_c);
    #1;
    chk("mdl_val", 32'(gpio_val), 32'(m_val));
    chk("mdl_status", 32'(irq_status), 32'(m_status));
    chk("mdl_irq", 32'(irq), 32'(|m_status));
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_val", 32'(gpio_val), 32'h0);
    chk("rst_status", 32'(irq_status), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic [W-1:0]  din;
    logic [W-1:0]  ren;
    logic [W-1:0]  fen;
    logic [DW-1:0] lim;
    logic [W-1:0]  exp_val;
    logic [W-1:0]  exp_status;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int exp_edge;

    vecs[0] = '{din: 18'h00F0F, ren: 18'h3FFFF, fen: 18'h00000, lim: 4'd2, exp_val: 18'h00F0F, exp_status: 18'h00F0F};
    vecs[1] = '{din: 18'h0F0F0, ren: 18'h00000, fen: 18'h3FFFF, lim: 4'd4, exp_val: 18'h0F0F0, exp_status: 18'h00F0F};
    vecs[2] = '{din: 18'h3FFFF, ren: 18'h00003, fen: 18'h3FFFF, lim: 4'd0, exp_val: 18'h3FFFF, exp_status: 18'h00003};
    vecs[3] = '{din: 18'h2AAAA, ren: 18'h3FFFF, fen: 18'h00001, lim: 4'd1, exp_val: 18'h2AAAA, exp_status: 18'h00001};

    // Reset sequencing with all inputs high and rise_en all ones.
    gpio_in    = 18'h3FFFF;
    rise_en    = 18'h3FFFF;
    dbnc_limit = 4'd0;
    @(posedge clk);
    #1;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rst_seq_val", 32'(gpio_val), (k >= 3) ? 32'h3FFFF : 32'h0);
    end
    chk("rst_seq_status", 32'(irq_status), 32'h3FFFF);

    // Bring everything low and clear status as a common baseline.
    gpio_in = '0;
    rise_en = '0;
    ticks(6);
    irq_clr = '1;
    tick();
    irq_clr = '0;
    chk("baseline_irq", 32'(irq), 32'h0);

    // Debounce on bit 5.
    dbnc_limit = 4'd4;
    rise_en    = 18'h00020;
    gpio_in[5] = 1'b1;
    exp_edge   = SYNC + eff_limit(4) + 1;
    for (int k = 1; k <= exp_edge + 1; k++) begin
      tick();
      chk("dbnc_b5_val", 32'(gpio_val[5]), (k >= exp_edge) ? 32'h1 : 32'h0);
      chk("dbnc_b5_status", 32'(irq_status[5]), (k >= exp_edge) ? 32'h1 : 32'h0);
    end

    // Glitch of 3 cycles on bit 0.
    rise_en[0] = 1'b1;
    gpio_in[0] = 1'b1;
    ticks(3);
    gpio_in[0] = 1'b0;
    ticks(10);
    chk("glitch_val", 32'(gpio_val[0]), 32'h0);
    chk("glitch_status", 32'(irq_status[0]), DBNC_ON ? 32'h0 : 32'h1);

    // Edge selection: only falling edge enabled on bit 7.
    irq_clr    = '1;
    tick();
    irq_clr    = '0;
    dbnc_limit = 4'd0;
    rise_en    = '0;
    fall_en    = 18'h00080;
    gpio_in[7] = 1'b1;
    ticks(5);
    chk("edge_rise_status", 32'(irq_status[7]), 32'h0);
    chk("edge_rise_irq", 32'(irq), 32'h0);
    gpio_in[7] = 1'b0;
    ticks(5);
    chk("edge_fall_status", 32'(irq_status[7]), 32'h1);
    chk("edge_fall_irq", 32'(irq), 32'h1);

    // Clear collides with a new rise update on bit 3.
    irq_clr    = '1;
    tick();
    irq_clr    = '0;
    fall_en    = '0;
    rise_en    = 18'h00008;
    gpio_in[3] = 1'b1;
    ticks(SYNC);
    irq_clr[3] = 1'b1;
    tick();
    irq_clr[3] = 1'b0;
    chk("collide_status", 32'(irq_status[3]), 32'h1);
    irq_clr    = '1;
    tick();
    irq_clr    = '0;
    chk("clear_status", 32'(irq_status[3]), 32'h0);
    chk("clear_irq", 32'(irq), 32'h0);

    // Reset in the middle of a debounce count on bit 2.
    dbnc_limit = 4'd8;
    rise_en    = 18'h00004;
    gpio_in[2] = 1'b1;
    ticks(SYNC + 5);
    chk("midcnt_pre_val", 32'(gpio_val[2]), DBNC_ON ? 32'h0 : 32'h1);
    do_reset();
    exp_edge = SYNC + eff_limit(8) + 1;
    for (int k = 1; k <= exp_edge + 1; k++) begin
      tick();
      chk("midcnt_val", 32'(gpio_val[2]), (k >= exp_edge) ? 32'h1 : 32'h0);
    end

    // Table-driven steady-state vectors.
    gpio_in = '0;
    ticks(12);
    for (int v = 0; v < 4; v++) begin
      irq_clr = '1;
      tick();
      irq_clr    = '0;
      gpio_in    = vecs[v].din;
      rise_en    = vecs[v].ren;
      fall_en    = vecs[v].fen;
      dbnc_limit = vecs[v].lim;
      ticks(10);
      chk($sformatf("vec%0d_val", v), 32'(gpio_val), 32'(vecs[v].exp_val));
      chk($sformatf("vec%0d_status", v), 32'(irq_status), 32'(vecs[v].exp_status));
    end

    // Randomized run against the model.
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        rise_en = W'($urandom);
        fall_en = W'($urandom);
      end
      if (c % 64 == 0) dbnc_limit = DW'($urandom_range(0, 5));
      if (c == 400) do_reset();
      if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ W'($urandom & $urandom);
      irq_clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      tick();
    end
    irq_clr = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
